shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter that shares one WIDTH-bit `Register` write port among NUM_CORES requesting cores in the multicore CPU. Each core requests ownership, and the granted core's write enable and data are registered and forwarded to the `Register` instance. Ownership is capped at HOLD_MAX cycles so no core can starve the others. The block sits between the per-core write paths and the shared `Register`, which is instantiated outside this block.

## Interface
- WIDTH, 12, data width; must match the shared `Register`
- NUM_CORES, 4, number of requesters; at least 2
- HOLD_MAX, 8, maximum cycles one grant may last; at least 1
- clock  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of `clock`
- req  input  NUM_CORES  per-core ownership request; level-sensitive
- writeEn  input  NUM_CORES  per-core write strobe; honoured only for the current owner
- dataIn  input  NUM_CORES*WIDTH  per-core write data; core i occupies bits [i*WIDTH +: WIDTH]
- grant  output  NUM_CORES  one-hot ownership indication; all zero when idle
- ownerId  output  clog2(NUM_CORES)  index of the current owner; valid only while busy=1
- busy  output  1  high in the OWN state
- regWriteEn  output  1  drives `Register.writeEn`
- regDataIn  output  WIDTH  drives `Register.dataIn`

## Operation
- Two states:
  - IDLE: no owner.
  - OWN: one owner, held in ownerId.
- Reset (rst=0 at an edge) sets the following; reset overrides everything, including mid-grant:
  - state=IDLE, grant=0, ownerId=0, busy=0
  - regWriteEn=0, regDataIn=0
  - rrPtr=0, holdCnt=0
- IDLE with any req bit high at an edge:
  - The winner is the first set bit found searching upward from rrPtr, wrapping modulo NUM_CORES.
  - state→OWN, grant=onehot(winner), ownerId=winner, holdCnt=0.
- IDLE with req=0: stay in IDLE.
- OWN, at each edge:
  - regWriteEn ← writeEn[owner] & req[owner].
  - regDataIn ← dataIn[owner] when that write is accepted; otherwise regDataIn holds its value.
  - writeEn from non-owners is ignored.
- OWN release: when req[owner]=0, or holdCnt==HOLD_MAX-1:
  - state→IDLE, grant=0, rrPtr ← (owner+1) mod NUM_CORES.
  - A write presented in the final cycle of a HOLD_MAX expiry is still accepted.
- OWN without release: holdCnt increments by 1; it never exceeds HOLD_MAX-1.
- In IDLE, regWriteEn=0 on every cycle.
- Simultaneous requests in IDLE are resolved purely by rrPtr order; no fixed priority exists.
- An owner that drops req and re-asserts it immediately does not keep ownership. It re-enters arbitration from IDLE with rrPtr already advanced past it.

## Timing
- Grant latency: 1 cycle from req high in IDLE to grant visible.
- Write latency:
  - Owner writeEn/dataIn at cycle k gives regWriteEn/regDataIn at k+1.
  - The `Register` captures at k+2, so `Register.dataOut` is updated after the k+2 edge.
- One idle bubble cycle follows every release; IDLE always lasts at least 1 cycle.
- Maximum owner tenure is HOLD_MAX cycles of grant=1.
- Worst-case wait for a continuously requesting core: (NUM_CORES-1)*(HOLD_MAX+1)+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `shared_reg_arbiter_pkg` contains:
  - the state enum (IDLE, OWN)
  - default constants for WIDTH, NUM_CORES, HOLD_MAX
  - the function computing the ownerId width
- Sub-module `rr_picker`: combinational round-robin search.
  - Inputs: req, rrPtr.
  - Outputs: winner index, anyReq.
- The top level holds the FSM, holdCnt, rrPtr and the output registers.

## Test plan
- Reset mid-grant: core 2 owns and writes 12'hABC; assert rst=0 for 1 cycle → next cycle grant=0, busy=0, regWriteEn=0, regDataIn=12'h000, and the next arbitration starts from core 0.
- Single requester: req=4'b0010; writeEn[1]=1 with dataIn 12'h456 one cycle after grant → regWriteEn=1, regDataIn=12'h456 one cycle later, `Register.dataOut`=12'h456 the cycle after that.
- Fairness: req=4'b1111 held constant with HOLD_MAX=8 → grants go cores 0,1,2,3,0; each grant lasts exactly 8 cycles followed by 1 idle cycle.
- Non-owner ignored: core 0 owns with writeEn[0]=0 while core 3 drives writeEn[3]=1, dataIn 12'h789 → regWriteEn stays 0 and regDataIn is unchanged.
- Early release: core 1 owns, drops req after 3 cycles while req[2]=1 → IDLE for 1 cycle, then grant=4'b0100; any writeEn[1] in the drop cycle is not forwarded.
- Expiry write: HOLD_MAX=1 with core 0 writing 12'h123 on its only grant cycle → regWriteEn=1, regDataIn=12'h123 on the next cycle, grant=0 on the same cycle.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and constants for the shared register write-port arbiter.
// Provides the FSM state enum, default sizes and the index-width helper.
package shared_reg_arbiter_pkg;

  localparam int DEF_WIDTH     = 12;
  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_HOLD_MAX  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Width of an index into n items, never below one bit.
  function automatic int idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_picker.sv
// Combinational round-robin search: first set req bit at or above rrPtr.
// Ports: req, rrPtr in; winner index and anyReq out.
module rr_picker
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int IW        = idw(DEF_NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IW-1:0]        rrPtr,
  output logic [IW-1:0]        winner,
  output logic                 anyReq
);

  logic [2*NUM_CORES-1:0] dbl;
  logic [NUM_CORES-1:0]   rot;
  logic [IW:0]            sum;

  // Rotate so that bit 0 of rot is core rrPtr; then the lowest
  // set bit of rot is the winner. Downward loop: lowest i wins.
  always_comb begin
    dbl    = {req, req} >> rrPtr;
    rot    = dbl[NUM_CORES-1:0];
    winner = '0;
    anyReq = 1'b0;
    sum    = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (rot[i]) begin
        anyReq = 1'b1;
        sum    = {1'b0, rrPtr} + (IW+1)'(i);
        if (sum >= (IW+1)'(NUM_CORES))
          sum = sum - (IW+1)'(NUM_CORES);
        winner = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner arbiter for one shared register write port.
// Ports: clock, rst(n), req/writeEn/dataIn in; grant, ownerId, busy, regWriteEn, regDataIn out.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int HOLD_MAX  = DEF_HOLD_MAX
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [NUM_CORES-1:0]       req,
  input  logic [NUM_CORES-1:0]       writeEn,
  input  logic [NUM_CORES*WIDTH-1:0] dataIn,
  output logic [NUM_CORES-1:0]       grant,
  output logic [idw(NUM_CORES)-1:0]  ownerId,
  output logic                       busy,
  output logic                       regWriteEn,
  output logic [WIDTH-1:0]           regDataIn
);

  localparam int IW = idw(NUM_CORES);
  localparam int HW = idw(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(NUM_CORES - 1);

  arb_state_t           state, state_n;
  logic [NUM_CORES-1:0] grant_n;
  logic [IW-1:0]        owner_n;
  logic                 busy_n;
  logic                 wen_n;
  logic [WIDTH-1:0]     data_n;
  logic [IW-1:0]        ptr, ptr_n;
  logic [HW-1:0]        hold, hold_n;

  logic [IW-1:0]        win;
  logic                 any;
  logic [WIDTH-1:0]     din [NUM_CORES];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_din
    assign din[i] = dataIn[i*WIDTH +: WIDTH];
  end

  rr_picker #(
    .NUM_CORES (NUM_CORES),
    .IW        (IW)
  ) u_pick (
    .req    (req),
    .rrPtr  (ptr),
    .winner (win),
    .anyReq (any)
  );

  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = ownerId;
    busy_n  = busy;
    wen_n   = 1'b0;
    data_n  = regDataIn;
    ptr_n   = ptr;
    hold_n  = hold;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n      = OWN;
          grant_n      = '0;
          grant_n[win] = 1'b1;
          owner_n      = win;
          busy_n       = 1'b1;
          hold_n       = '0;
        end
      end
      OWN: begin
        // Write is still taken on the expiry cycle; a dropped
        // req blocks the owner's write in the same cycle.
        wen_n = writeEn[ownerId] & req[ownerId];
        if (wen_n)
          data_n = din[ownerId];
        if (!req[ownerId] || hold == HOLD_LAST) begin
          state_n = IDLE;
          grant_n = '0;
          busy_n  = 1'b0;
          ptr_n   = (ownerId == LAST_ID) ? '0
                                         : ownerId + 1'b1;
        end else begin
          hold_n = hold + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      ownerId    <= '0;
      busy       <= 1'b0;
      regWriteEn <= 1'b0;
      regDataIn  <= '0;
      ptr        <= '0;
      hold       <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      ownerId    <= owner_n;
      busy       <= busy_n;
      regWriteEn <= wen_n;
      regDataIn  <= data_n;
      ptr        <= ptr_n;
      hold       <= hold_n;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios plus random traffic
// against a behavioural model, on HOLD_MAX=8 and HOLD_MAX=1 instances.
module tb_shared_reg_arbiter;

  localparam int W = 12;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   writeEn = '0;
  logic [N*W-1:0] dataIn = '0;

  logic [N-1:0] g0, g1;
  logic [1:0]   o0, o1;
  logic         b0, b1;
  logic         we0, we1;
  logic [W-1:0] d0, d1;

  logic [W-1:0] regq = '0;

  int total = 0;
  int npass = 0;

  shared_reg_arbiter #(.WIDTH(W), .NUM_CORES(N), .HOLD_MAX(8)) u0 (
    .clock(clock), .rst(rst), .req(req), .writeEn(writeEn),
    .dataIn(dataIn), .grant(g0), .ownerId(o0), .busy(b0),
    .regWriteEn(we0), .regDataIn(d0)
  );

  shared_reg_arbiter #(.WIDTH(W), .NUM_CORES(N), .HOLD_MAX(1)) u1 (
    .clock(clock), .rst(rst), .req(req), .writeEn(writeEn),
    .dataIn(dataIn), .grant(g1), .ownerId(o1), .busy(b1),
    .regWriteEn(we1), .regDataIn(d1)
  );

  always #5 clock = ~clock;

  // Stand-in for the external shared Register fed by u0.
  always @(posedge clock)
    if (we0) regq <= d0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Behavioural model: owner = -1 when idle; tenure counts grant cycles.
  int         m_own [2];
  int         m_ptr [2];
  int         m_ten [2];
  int         m_oid [2];
  bit         m_we  [2];
  logic [W-1:0] m_d [2];
  bit         m_ok  [2];
  int         hmax  [2];

  task automatic step(input int u);
    int c;
    if (!rst) begin
      m_own[u] = -1; m_ptr[u] = 0; m_ten[u] = 0;
      m_oid[u] = 0;  m_we[u] = 0;  m_d[u] = '0;
      m_ok[u] = 1;
    end else if (m_own[u] < 0) begin
      m_we[u] = 0;
      for (int i = 0; i < N; i++) begin
        c = (m_ptr[u] + i) % N;
        if (m_own[u] < 0 && req[c]) begin
          m_own[u] = c; m_oid[u] = c; m_ten[u] = 1;
        end
      end
    end else begin
      c = m_own[u];
      m_we[u] = writeEn[c] && req[c];
      if (m_we[u]) m_d[u] = dataIn[c*W +: W];
      if (!req[c] || m_ten[u] >= hmax[u]) begin
        m_own[u] = -1;
        m_ptr[u] = (c + 1) % N;
      end else begin
        m_ten[u]++;
      end
    end
  endtask

  initial begin
    logic [N-1:0] eg, ag;
    logic         ab, aw;
    logic [W-1:0] ad;
    logic [1:0]   ao;
    bit           ok;
    hmax[0] = 8; hmax[1] = 1;
    m_ok[0] = 0; m_ok[1] = 0;
    forever begin
      @(negedge clock);
      for (int u = 0; u < 2; u++) begin
        if (m_ok[u]) begin
          ag = u == 0 ? g0 : g1;
          ab = u == 0 ? b0 : b1;
          aw = u == 0 ? we0 : we1;
          ad = u == 0 ? d0 : d1;
          ao = u == 0 ? o0 : o1;
          eg = m_own[u] < 0 ? '0 : N'(1 << m_own[u]);
          ok = (ag === eg) && (ab === (m_own[u] >= 0)) &&
               (aw === m_we[u]) && (ad === m_d[u]);
          if (m_own[u] >= 0 && ao !== 2'(m_oid[u])) ok = 0;
          total++;
          if (ok) npass++;
          else $display("FAIL model u%0d t=%0t: g=%b b=%b we=%b d=%h o=%0d exp g=%b b=%b we=%b d=%h o=%0d",
                        u, $time, ag, ab, aw, ad, ao, eg,
                        m_own[u] >= 0, m_we[u], m_d[u], m_oid[u]);
        end
        step(u);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setd(input int c, input logic [W-1:0] v);
    dataIn[c*W +: W] = v;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_grant", 32'(g0), 0);
    chk("rst_busy", 32'(b0), 0);
    chk("rst_we", 32'(we0), 0);
    chk("rst_data", 32'(d0), 0);
    rst = 1;

    // Single requester, write latency, Register capture
    req = 4'b0010;
    tick();
    chk("single_grant", 32'(g0), 32'h2);
    chk("single_owner", 32'(o0), 1);
    chk("single_busy", 32'(b0), 1);
    writeEn = 4'b0010; setd(1, 12'h456);
    tick();
    chk("single_we", 32'(we0), 1);
    chk("single_data", 32'(d0), 32'h456);
    chk("h1_grant_off", 32'(g1), 0);
    chk("h1_we", 32'(we1), 1);
    writeEn = 0;
    tick();
    chk("reg_dataout", 32'(regq), 32'h456);
    chk("single_we_off", 32'(we0), 0);
    req = 0;
    tick(); tick();

    // Reset mid-grant (pointer is at core 2 now)
    req = 4'b0100;
    tick();
    chk("c2_grant", 32'(g0), 32'h4);
    writeEn = 4'b0100; setd(2, 12'hABC);
    tick();
    chk("c2_data", 32'(d0), 32'hABC);
    rst = 0;
    tick();
    chk("mid_rst_grant", 32'(g0), 0);
    chk("mid_rst_busy", 32'(b0), 0);
    chk("mid_rst_we", 32'(we0), 0);
    chk("mid_rst_data", 32'(d0), 0);
    rst = 1; writeEn = 0; req = 4'b1111;

    // Fairness: 0,1,2,3,0; 8 grant cycles then 1 idle each
    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < 8; t++) begin
        tick();
        chk($sformatf("fair_k%0d_t%0d", k, t), 32'(g0),
            32'(1 << (k % 4)));
      end
      tick();
      chk($sformatf("fair_idle_k%0d", k), 32'(g0), 0);
    end
    req = 0;
    tick(); tick();
    rst = 0; tick(); rst = 1;

    // Non-owner write ignored
    req = 4'b0001;
    tick();
    chk("c0_grant", 32'(g0), 32'h1);
    writeEn = 4'b0001; setd(0, 12'h111);
    tick();
    chk("c0_data", 32'(d0), 32'h111);
    writeEn = 4'b1000; setd(3, 12'h789); req = 4'b1001;
    tick();
    chk("nonowner_we", 32'(we0), 0);
    chk("nonowner_data", 32'(d0), 32'h111);
    tick();
    chk("nonowner_data2", 32'(d0), 32'h111);
    req = 0; writeEn = 0;
    tick(); tick();

    // Early release of core 1 with core 2 waiting
    req = 4'b0110;
    tick();
    chk("er_grant1", 32'(g0), 32'h2);
    tick(); tick();
    req = 4'b0100; writeEn = 4'b0010; setd(1, 12'hFFF);
    tick();
    chk("er_idle", 32'(g0), 0);
    chk("er_we", 32'(we0), 0);
    chk("er_data", 32'(d0), 32'h111);
    writeEn = 0;
    tick();
    chk("er_grant2", 32'(g0), 32'h4);
    req = 0;
    tick(); tick();

    // HOLD_MAX=1 expiry write
    rst = 0; tick(); rst = 1;
    req = 4'b0001;
    tick();
    chk("exp_grant", 32'(g1), 32'h1);
    writeEn = 4'b0001; setd(0, 12'h123);
    tick();
    chk("exp_grant_off", 32'(g1), 0);
    chk("exp_we", 32'(we1), 1);
    chk("exp_data", 32'(d1), 32'h123);
    writeEn = 0; req = 0;
    tick(); tick();

    // Random traffic checked by the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      writeEn = N'($urandom);
      dataIn = (N*W)'({$urandom, $urandom});
      rst = ($urandom_range(0, 63) != 0);
      tick();
    end
    rst = 1;
    tick(); tick();
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
